// File: rtl/xif_result_stage.sv
// rtl/xif_result_stage.sv - in-order FPU result buffer gated by per-id commit/kill status
module xif_result_stage #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFW_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [X_ID_WIDTH-1:0]  in_id,
  input  logic [X_RFW_WIDTH-1:0] in_data,
  input  logic [4:0]             in_rd,
  input  logic                   in_we,
  input  logic                   in_exc,
  input  logic [5:0]             in_exccode,
  input  logic                   commit_valid,
  input  logic [X_ID_WIDTH-1:0]  commit_id,
  input  logic                   commit_kill,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [X_ID_WIDTH-1:0]  result_id,
  output logic [X_RFW_WIDTH-1:0] result_data,
  output logic [4:0]             result_rd,
  output logic                   result_we,
  output logic                   result_exc,
  output logic [5:0]             result_exccode,
  output logic [5:0]             result_ecsdata,
  output logic [2:0]             result_ecswe,
  output logic                   result_err,
  output logic                   result_dbg
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NID = 1 << X_ID_WIDTH;
  localparam int EW  = X_ID_WIDTH + X_RFW_WIDTH + 13;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [EW-1:0]         mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [AW:0]           count;
  logic [NID-1:0]        committed;
  logic [NID-1:0]        killed;
  logic [EW-1:0]         head;
  logic [X_ID_WIDTH-1:0] head_id;
  logic                  head_ok;
  logic                  send;
  logic                  drop;
  logic                  push;
  logic                  pop;

  assign head    = mem[rptr];
  assign head_id = head[EW-1 -: X_ID_WIDTH];

  // Head decode uses only registered state, so result_* never sees in_*/commit_* combinationally.
  assign head_ok = (count != '0) && committed[head_id];
  assign send    = head_ok && !killed[head_id];
  assign drop    = head_ok && killed[head_id];

  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = drop || (send && result_ready);

  assign result_valid = send;
  assign {result_id, result_data, result_rd, result_we, result_exc, result_exccode} =
      send ? head : '0;

  assign result_ecsdata = '0;
  assign result_ecswe   = '0;
  assign result_err     = 1'b0;
  assign result_dbg     = 1'b0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= {in_id, in_data, in_rd, in_we, in_exc, in_exccode};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      committed <= '0;
      killed    <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      // The later commit assignment wins when it targets the id being popped.
      if (pop) begin
        committed[head_id] <= 1'b0;
        killed[head_id]    <= 1'b0;
      end
      if (commit_valid) begin
        committed[commit_id] <= 1'b1;
        killed[commit_id]    <= commit_kill;
      end
    end
  end

endmodule

// File: tb/tb_xif_result_stage.sv
// tb/tb_xif_result_stage.sv - directed and randomized checks of xif_result_stage against a queue model
module tb_xif_result_stage;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic [5:0]  code;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_id;
  logic [31:0] in_data;
  logic [4:0]  in_rd;
  logic        in_we, in_exc;
  logic [5:0]  in_exccode;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic        commit_kill;
  logic        result_valid, result_ready;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic        result_we, result_exc;
  logic [5:0]  result_exccode;
  logic [5:0]  result_ecsdata;
  logic [2:0]  result_ecswe;
  logic        result_err, result_dbg;

  int compared   = 0;
  int mismatched = 0;

  ent_t q[$];
  bit   m_com[16];
  bit   m_kil[16];
  bit   m_send, m_drop, m_ready;
  ent_t m_head;

  xif_result_stage #(.X_ID_WIDTH(4), .X_RFW_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_data(in_data),
    .in_rd(in_rd), .in_we(in_we), .in_exc(in_exc), .in_exccode(in_exccode),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
    .result_data(result_data), .result_rd(result_rd), .result_we(result_we),
    .result_exc(result_exc), .result_exccode(result_exccode),
    .result_ecsdata(result_ecsdata), .result_ecswe(result_ecswe),
    .result_err(result_err), .result_dbg(result_dbg)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 16; i++) begin
      m_com[i] = 1'b0;
      m_kil[i] = 1'b0;
    end
  endtask

  task automatic model_eval();
    m_ready = (q.size() < DEPTH);
    m_send  = 1'b0;
    m_drop  = 1'b0;
    m_head  = '0;
    if (q.size() > 0 && m_com[q[0].id]) begin
      m_head = q[0];
      m_send = !m_kil[q[0].id];
      m_drop = m_kil[q[0].id];
    end
  endtask

  // Advance one clock: the model applies the same cycle's inputs as the DUT sees at the edge.
  task automatic tick();
    bit   pop, push;
    ent_t e;
    model_eval();
    pop  = m_drop || (m_send && result_ready);
    push = in_valid && m_ready;
    e    = '{id: in_id, data: in_data, rd: in_rd, we: in_we, exc: in_exc, code: in_exccode};
    @(posedge clk);
    if (pop) begin
      m_com[q[0].id] = 1'b0;
      m_kil[q[0].id] = 1'b0;
      void'(q.pop_front());
    end
    if (push) q.push_back(e);
    if (commit_valid) begin
      m_com[commit_id] = 1'b1;
      m_kil[commit_id] = commit_kill;
    end
    #1;
    model_eval();
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_id = 0; in_data = 0; in_rd = 0; in_we = 0; in_exc = 0; in_exccode = 0;
    commit_valid = 0; commit_id = 0; commit_kill = 0; result_ready = 0;
  endtask

  task automatic push_in(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd);
    in_valid = 1; in_id = id; in_data = data; in_rd = rd; in_we = 1; in_exc = 0; in_exccode = 0;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid = 1; commit_id = id; commit_kill = kill;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    compared++;
    if (in_ready !== 1'b1 || result_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_handshake: in_ready=%b result_valid=%b required 1/0", in_ready, result_valid);
    end
    compared++;
    if ({result_id, result_data, result_rd, result_we, result_exc, result_exccode,
         result_ecsdata, result_ecswe, result_err, result_dbg} !== '0) begin
      mismatched++;
      $display("FAIL reset_fields: id=%h data=%h rd=%h required all 0", result_id, result_data, result_rd);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    tick();
    compared++;
    if (dut.count !== 0 || result_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle: count=%0d valid=%b required 0/0", dut.count, result_valid);
    end
  endtask

  task automatic test_min_latency();
    idle_inputs();
    commit(4'd3, 1'b0);
    tick();
    commit_valid = 0;
    tick();
    push_in(4'd3, 32'h3F80_0000, 5'd5);
    result_ready = 1;
    tick();
    in_valid = 0;
    compared++;
    if (result_valid !== 1'b1 || result_id !== 4'd3 || result_data !== 32'h3F80_0000 || result_rd !== 5'd5) begin
      mismatched++;
      $display("FAIL min_latency: valid=%b id=%0d data=%h rd=%0d required 1/3/3f800000/5",
               result_valid, result_id, result_data, result_rd);
    end
    tick();
    compared++;
    if (result_valid !== 1'b0 || dut.count !== 0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL min_latency_empty: valid=%b count=%0d ready=%b required 0/0/1",
               result_valid, dut.count, in_ready);
    end
  endtask

  task automatic test_in_order_commit();
    idle_inputs();
    result_ready = 1;
    push_in(4'd1, 32'hAAAA_0001, 5'd1);
    tick();
    push_in(4'd2, 32'hBBBB_0002, 5'd2);
    tick();
    in_valid = 0;
    commit(4'd2, 1'b0);
    tick();
    commit_valid = 0;
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (result_valid !== 1'b0 || dut.count !== 2) begin
        mismatched++;
        $display("FAIL blocked_head: valid=%b count=%0d required 0/2", result_valid, dut.count);
      end
      tick();
    end
    commit(4'd1, 1'b0);
    tick();
    commit_valid = 0;
    compared++;
    if (result_valid !== 1'b1 || result_id !== 4'd1 || result_data !== 32'hAAAA_0001) begin
      mismatched++;
      $display("FAIL order_first: valid=%b id=%0d data=%h required 1/1/aaaa0001", result_valid, result_id, result_data);
    end
    tick();
    compared++;
    if (result_valid !== 1'b1 || result_id !== 4'd2 || result_data !== 32'hBBBB_0002) begin
      mismatched++;
      $display("FAIL order_second: valid=%b id=%0d data=%h required 1/2/bbbb0002", result_valid, result_id, result_data);
    end
    tick();
    compared++;
    if (result_valid !== 1'b0 || dut.count !== 0) begin
      mismatched++;
      $display("FAIL order_drain: valid=%b count=%0d required 0/0", result_valid, dut.count);
    end
  endtask

  task automatic test_kill();
    idle_inputs();
    result_ready = 1;
    push_in(4'd7, 32'h0000_0777, 5'd7);
    tick();
    in_valid = 0;
    commit(4'd7, 1'b1);
    tick();
    commit_valid = 0;
    compared++;
    if (result_valid !== 1'b0 || dut.count !== 1) begin
      mismatched++;
      $display("FAIL kill_visible: valid=%b count=%0d required 0/1", result_valid, dut.count);
    end
    tick();
    compared++;
    if (result_valid !== 1'b0 || dut.count !== 0) begin
      mismatched++;
      $display("FAIL kill_dropped: valid=%b count=%0d required 0/0", result_valid, dut.count);
    end
  endtask

  task automatic test_full();
    logic [3:0] ids [4];
    ids = '{4'd4, 4'd5, 4'd6, 4'd8};
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      push_in(ids[i], 32'h1000 + i, 5'(i + 10));
      commit(ids[i], 1'b0);
      tick();
    end
    commit_valid = 0;
    push_in(4'd9, 32'hDEAD_BEEF, 5'd31);
    for (int i = 0; i < 2; i++) begin
      compared++;
      if (in_ready !== 1'b0 || dut.count !== 4) begin
        mismatched++;
        $display("FAIL full_hold: in_ready=%b count=%0d required 0/4", in_ready, dut.count);
      end
      tick();
    end
    result_ready = 1;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (result_valid !== 1'b1 || result_id !== ids[i] || result_data !== 32'(32'h1000 + i)) begin
        mismatched++;
        $display("FAIL full_drain[%0d]: valid=%b id=%0d data=%h required 1/%0d/%h",
                 i, result_valid, result_id, result_data, ids[i], 32'h1000 + i);
      end
      tick();
      // The pop from a full buffer must not admit the held entry in the same cycle.
      if (i == 0) begin
        in_valid = 0;
        compared++;
        if (dut.count !== 3) begin
          mismatched++;
          $display("FAIL no_push_through: count=%0d required 3", dut.count);
        end
      end
    end
    compared++;
    if (in_ready !== 1'b1 || dut.count !== 0 || result_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL full_empty: in_ready=%b count=%0d valid=%b required 1/0/0", in_ready, dut.count, result_valid);
    end
  endtask

  task automatic test_stall_and_reset();
    idle_inputs();
    push_in(4'd10, 32'hCAFE_F00D, 5'd17);
    in_exc = 1; in_exccode = 6'd21;
    commit(4'd10, 1'b0);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (result_valid !== 1'b1 || result_id !== 4'd10 || result_data !== 32'hCAFE_F00D ||
          result_rd !== 5'd17 || result_we !== 1'b1 || result_exc !== 1'b1 || result_exccode !== 6'd21) begin
        mismatched++;
        $display("FAIL stall_stable[%0d]: valid=%b id=%0d data=%h rd=%0d exc=%b code=%0d required 1/10/cafef00d/17/1/21",
                 i, result_valid, result_id, result_data, result_rd, result_exc, result_exccode);
      end
      tick();
    end
    result_ready = 1;
    tick();
    compared++;
    if (result_valid !== 1'b0 || dut.count !== 0) begin
      mismatched++;
      $display("FAIL stall_single_pop: valid=%b count=%0d required 0/0", result_valid, dut.count);
    end
    result_ready = 0;
    push_in(4'd11, 32'h1111_1111, 5'd3);
    commit(4'd11, 1'b0);
    tick();
    push_in(4'd12, 32'h2222_2222, 5'd4);
    commit(4'd12, 1'b0);
    tick();
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if (result_valid !== 1'b0 || in_ready !== 1'b1 || result_id !== 4'd0 || result_data !== 32'd0) begin
      mismatched++;
      $display("FAIL mid_reset: valid=%b in_ready=%b id=%0d data=%h required 0/1/0/0",
               result_valid, in_ready, result_id, result_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    result_ready = 1;
    tick();
    tick();
    compared++;
    if (result_valid !== 1'b0 || dut.count !== 0) begin
      mismatched++;
      $display("FAIL post_reset: valid=%b count=%0d required 0/0", result_valid, dut.count);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid     = ($urandom_range(0, 1) == 1);
      in_id        = 4'($urandom_range(0, 3));
      in_data      = $urandom;
      in_rd        = 5'($urandom);
      in_we        = 1'($urandom);
      in_exc       = 1'($urandom);
      in_exccode   = 6'($urandom);
      commit_valid = ($urandom_range(0, 9) < 4);
      commit_id    = 4'($urandom_range(0, 3));
      commit_kill  = ($urandom_range(0, 3) == 0);
      result_ready = ($urandom_range(0, 9) < 6);
      tick();
      compared++;
      if (result_valid !== m_send || in_ready !== m_ready || dut.count !== q.size() ||
          (m_send && {result_id, result_data, result_rd, result_we, result_exc, result_exccode} !== m_head)) begin
        mismatched++;
        if (errs++ < 10)
          $display("FAIL random[%0d]: valid=%b ready=%b count=%0d id=%0d data=%h required %b/%b/%0d/%0d/%h",
                   c, result_valid, in_ready, dut.count, result_id, result_data,
                   m_send, m_ready, q.size(), m_head.id, m_head.data);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_min_latency();
    test_in_order_commit();
    test_kill();
    test_full();
    test_stall_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
